// File: rtl/cs_frame_gen.sv
// Multi-channel chip-select frame generator: setup guard, divided tick train, hold guard.
// Optional back-to-back frame repeat while start stays high: define CS_FRAME_REPEAT_EN.
module cs_frame_gen #(
  parameter  int N_CH      = 2,
  parameter  int CNT_WIDTH = 5,
  parameter  int DIV_WIDTH = 8,
  parameter  int SETUP     = 1,
  parameter  int HOLD      = 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [CNT_WIDTH-1:0] frame_len,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [N_CH-1:0]      cs,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  localparam int GMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD} state_t;
  localparam state_t FIRST = (SETUP == 0) ? S_ACTIVE : S_SETUP;

  state_t               state, nstate;
  logic                 start_q, start_edge;
  logic                 load, done_nxt;
  logic [CH_W-1:0]      ch_q;
  logic [CNT_WIDTH-1:0] len_q, tcnt;
  logic [DIV_WIDTH-1:0] div_q, phase;
  logic [GW-1:0]        gcnt;
  logic                 cfg_ok, setup_end, hold_end, last_wrap, frame_end;

  assign start_edge = start & ~start_q;
  assign cfg_ok     = (frame_len != '0) && (32'(ch_sel) < 32'(N_CH));
  assign setup_end  = (gcnt == GW'(SETUP - 1));
  assign hold_end   = (gcnt == GW'(HOLD - 1));
  assign last_wrap  = (state == S_ACTIVE) && (phase == div_q) &&
                      (tcnt == len_q - CNT_WIDTH'(1));
  assign frame_end  = (HOLD == 0) ? last_wrap : ((state == S_HOLD) && hold_end);

  // start_q resets high so a start held through reset is not seen as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= nstate;
      start_q <= start;
      done    <= done_nxt;
    end
  end

  always_comb begin
    nstate   = state;
    load     = 1'b0;
    done_nxt = 1'b0;
    unique case (state)
      S_IDLE:   if (start_edge && cfg_ok) begin
                  load   = 1'b1;
                  nstate = FIRST;
                end
      S_SETUP:  if (setup_end) nstate = S_ACTIVE;
      S_ACTIVE: if (last_wrap) nstate = (HOLD == 0) ? S_IDLE : S_HOLD;
      S_HOLD:   if (hold_end) nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
    if (frame_end) begin
      done_nxt = 1'b1;
`ifdef CS_FRAME_REPEAT_EN
      if (start && cfg_ok) begin
        load   = 1'b1;
        nstate = FIRST;
      end
`endif
    end
    if (abort && state != S_IDLE) begin
      nstate   = S_IDLE;
      load     = 1'b0;
      done_nxt = 1'b0;
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
    cs   = busy ? (N_CH'(1) << ch_q) : '0;
    tick = (state == S_ACTIVE) && (phase == '0);
  end

  // config latch and counters; load clears everything for the new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      len_q <= '0;
      div_q <= '0;
      phase <= '0;
      tcnt  <= '0;
      gcnt  <= '0;
    end else if (load) begin
      ch_q  <= ch_sel;
      len_q <= frame_len;
      div_q <= div;
      phase <= '0;
      tcnt  <= '0;
      gcnt  <= '0;
    end else begin
      unique case (state)
        S_SETUP:  gcnt <= setup_end ? '0 : gcnt + GW'(1);
        S_ACTIVE: if (phase == div_q) begin
                    phase <= '0;
                    tcnt  <= tcnt + CNT_WIDTH'(1);
                  end else begin
                    phase <= phase + DIV_WIDTH'(1);
                  end
        S_HOLD:   gcnt <= gcnt + GW'(1);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_frame_gen.sv
// Scoreboard bench for cs_frame_gen: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_cs_frame_gen;
  localparam int N_CH = 2, CW = 5, DW = 8, S = 1, H = 1;
  localparam int VW = N_CH + 3;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [0:0]      ch_sel;
  logic [CW-1:0]   frame_len;
  logic [DW-1:0]   div;
  logic [N_CH-1:0] cs;
  logic            tick, busy, done;

  cs_frame_gen #(.N_CH(N_CH), .CNT_WIDTH(CW), .DIV_WIDTH(DW), .SETUP(S), .HOLD(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_sel(ch_sel),
    .frame_len(frame_len), .div(div), .cs(cs), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [VW-1:0] v; } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0;

  function automatic logic [VW-1:0] pack(logic [N_CH-1:0] c, logic t, logic b, logic d);
    return {c, t, b, d};
  endfunction

  task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got cs=%b tick=%b busy=%b done=%b, want cs=%b tick=%b busy=%b done=%b",
               nm, act[VW-1:3], act[2], act[1], act[0], exp[VW-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++; errs++;
      $display("FAIL sched: expectation for cycle %0d not reached (now %0d)", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk($sformatf("cyc%0d", cyc), pack(cs, tick, busy, done), e.v);
    end
  end

  task automatic push_idle(int from, int n);
    for (int i = 0; i < n; i++) q.push_back('{cyc: from + i, v: pack('0, 1'b0, 1'b0, 1'b0)});
  endtask

  // Relative cycle r=1 is the first cycle after the edge that samples start.
  task automatic push_frame(int b, int ch, int len, int dv, int last);
    int act, tot;
    act = len * (dv + 1);
    tot = S + act + H;
    for (int r = 1; r <= last; r++) begin
      logic in_f, t, d;
      logic [N_CH-1:0] c;
      in_f = (r <= tot);
      c    = in_f ? (N_CH'(1) << ch) : '0;
      t    = in_f && (r > S) && (r <= S + act) && (((r - S - 1) % (dv + 1)) == 0);
      d    = (r == tot + 1);
      q.push_back('{cyc: b + r - 1, v: pack(c, t, in_f, d)});
    end
  endtask

  task automatic raise(int ch, int len, int dv, output int b);
    @(posedge clk); #1;
    ch_sel    = 1'(ch);
    frame_len = CW'(len);
    div       = DW'(dv);
    start     = 1'b1;
    b         = cyc + 1;
  endtask

  task automatic wait_rel(int b, int r);
    while (cyc < b + r - 1) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int b, b2;
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    ch_sel = '0; frame_len = '0; div = '0;
    push_idle(1, 2);
    repeat (3) @(posedge clk);
    #1;
    // start still high at release: must not open a frame
    rst = 1'b0;
    push_idle(cyc, 6);
    wait_rel(cyc, 7);
    start = 1'b0;

    // basic frame: ch1, len 4, div 1
    raise(1, 4, 1, b);
    push_frame(b, 1, 4, 1, 13);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 14);

    // div 0: tick every active cycle
    raise(0, 3, 0, b);
    push_frame(b, 0, 3, 0, 8);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 9);

    // frame_len 0 is ignored
    raise(1, 0, 1, b);
    push_idle(b, 6);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 7);

    // abort during cycle 5, then a fresh full frame
    raise(1, 4, 1, b);
    push_frame(b, 1, 4, 1, 5);
    push_idle(b + 5, 2);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 5); abort = 1'b1;
    wait_rel(b, 6); abort = 1'b0;
    raise(1, 4, 1, b2);
    push_frame(b2, 1, 4, 1, 13);
    wait_rel(b2, 1); start = 1'b0;
    wait_rel(b2, 14);

    // second start edge and config change mid-frame are ignored
    raise(1, 4, 1, b);
    push_frame(b, 1, 4, 1, 13);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 3); start = 1'b1; ch_sel = 1'b0; frame_len = CW'(7);
    wait_rel(b, 5); start = 1'b0;
    wait_rel(b, 14);

    // start held high across frame end
    raise(1, 2, 0, b);
`ifdef CS_FRAME_REPEAT_EN
    for (int r = 1; r <= 15; r++) begin
      logic in_f;
      int fr;
      in_f = (r <= 12);
      fr   = (r - 1) % 4 + 1;
      q.push_back('{cyc: b + r - 1,
                    v: pack(in_f ? 2'b10 : 2'b00, in_f && (fr == 2 || fr == 3), in_f,
                            (r == 5 || r == 9 || r == 13))});
    end
`else
    push_frame(b, 1, 2, 0, 15);
`endif
    wait_rel(b, 10); start = 1'b0;
    wait_rel(b, 16);

    // asynchronous reset in the middle of ACTIVE
    raise(1, 4, 1, b);
    push_frame(b, 1, 4, 1, 3);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 4);
    #2 rst = 1'b1;
    #1 chk("async_rst", pack(cs, tick, busy, done), pack('0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    push_idle(cyc, 3);
    wait_rel(cyc, 4);
    raise(0, 3, 0, b);
    push_frame(b, 0, 3, 0, 8);
    wait_rel(b, 1); start = 1'b0;
    wait_rel(b, 9);

    @(posedge clk); #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++; errs++;
      $display("FAIL drain: expectation for cycle %0d never checked", e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cs_frame_gen.md
Name: cs_frame_gen

Overview:
- Parametrised multi-channel chip-select frame generator for the delay core's SPI-style converter/memory interfaces.
- A rising edge on start opens one frame on a selected channel: setup guard, then a programmable number of divided clock-enable ticks, then hold guard.
- Adds runtime frame length, runtime tick divider, abort, and busy/done status.
- Successor to the fixed-threshold chip-select and pulse-train generators.

Parameters:
- N_CH, 2, number of chip-select channels (>=1).
- CNT_WIDTH, 5, width of the frame_len input and the tick counter.
- DIV_WIDTH, 8, width of the div input and the phase counter.
- SETUP, 1, cycles cs is asserted before the first tick (0 allowed).
- HOLD, 1, cycles cs stays asserted after the last tick period (0 allowed).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request, level; a rising edge is detected internally.
- abort  input  1  synchronous abort of the current frame.
- ch_sel  input  max(1,$clog2(N_CH))  target channel, latched on the start edge.
- frame_len  input  CNT_WIDTH  ticks per frame, latched on the start edge.
- div  input  DIV_WIDTH  tick period minus 1, latched on the start edge.
- cs  output  N_CH  one-hot active-high chip selects.
- tick  output  1  one-cycle clock-enable pulse inside the frame.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: cs=0, tick=0, busy=0, done=0.
  - Internal: state=IDLE, counters=0, latched config=0.
  - start_q resets to 1, so a start held high through reset does not trigger.
- Edge detect: start_q<=start every cycle, in every state; start_edge = start & ~start_q.
- FSM states: IDLE, SETUP, ACTIVE, HOLD.
- IDLE:
  - On start_edge with frame_len!=0: latch ch_sel/frame_len/div, clear counters. Next state is SETUP, or ACTIVE if SETUP==0.
  - start_edge with frame_len==0 is ignored: stay IDLE, no done.
  - ch_sel>=N_CH is ignored the same way.
- SETUP: cs[ch]=1 for exactly SETUP cycles, then ACTIVE.
- ACTIVE:
  - Phase counter counts 0..div and wraps.
  - tick=1 when phase==0.
  - Tick counter increments on each wrap.
  - Lasts exactly frame_len*(div+1) cycles; after the final wrap go to HOLD, or IDLE if HOLD==0.
  - div=0 gives tick high every ACTIVE cycle.
- HOLD: cs held for HOLD cycles, then IDLE.
- done:
  - Registered; asserted in the first IDLE cycle after normal completion, for exactly 1 cycle.
- Output timing:
  - cs, tick and busy are decoded from registered state/counters, so they are glitch-free.
  - cs is zero in IDLE.
  - busy = (state!=IDLE).
- Latency: start edge sampled at posedge k gives cs high from cycle k+1. Total busy cycles = SETUP + frame_len*(div+1) + HOLD.
- Config stability: inputs are latched once per frame; changes to ch_sel/frame_len/div while busy have no effect on the running frame.
- Start while busy: start_edge while busy is dropped, not queued.
- Abort:
  - abort=1 in any non-IDLE state goes to IDLE next cycle: cs=0, tick=0, no done.
  - abort in IDLE has no effect.
  - abort has priority over start_edge in the same cycle.
- Counter widths: tick counter is CNT_WIDTH and phase counter is DIV_WIDTH. No overflow is possible because the compare is against latched values; max frame_len=2^CNT_WIDTH-1.

Optional Feature:
- Macro: CS_FRAME_REPEAT_EN.
- When defined:
  - At the end of HOLD (or ACTIVE if HOLD==0), if start is still high and abort=0, re-latch the inputs and go straight to SETUP/ACTIVE without visiting IDLE.
  - cs stays continuously asserted if ch_sel is unchanged.
  - done pulses for 1 cycle on each frame boundary, coincident with the first cycle of the next frame.
  - busy stays high.
  - A re-latched frame_len==0 ends the repeat to IDLE with done.
- When undefined: a frame always returns to IDLE, and a new start rising edge is required.

Test Plan:
- Basic frame (SETUP=1, HOLD=1; frame_len=4, div=1, ch_sel=1; start rises, sampled at cycle 0):
  - cs=2'b10 for cycles 1-10.
  - tick at cycles 2, 4, 6, 8.
  - busy for cycles 1-10.
  - done=1 at cycle 11 only.
  - cs[0] never asserted.
- div=0, frame_len=3, ch_sel=0:
  - tick high at cycles 2, 3, 4.
  - cs[0] high for cycles 1-5.
  - done at cycle 6.
- frame_len=0 start edge: no cs, busy or done. Start held high from reset release: no frame until start goes low then high.
- Abort at cycle 5 of the basic frame: cs=0 and busy=0 from cycle 6, no done. A new start edge at cycle 8 runs a full frame.
- Second start edge at cycle 4 of the basic frame, and ch_sel/frame_len changed to 0/7 mid-frame: frame is unchanged (4 ticks on cs[1]), only one done.
- With CS_FRAME_REPEAT_EN, start held high for frame_len=2, div=0:
  - cs[1] continuously high.
  - done pulses every 4 cycles.
  - Dropping start ends the sequence after the current HOLD with a final done.
- Without the macro, the same stimulus gives exactly one frame.
- rst asserted mid-ACTIVE: all outputs 0 immediately (asynchronous), state IDLE.
